// File: rtl/operand_pair_fifo_pkg.sv
// rtl/operand_pair_fifo_pkg.sv - shared defaults and width helper for the operand pair fifo
package operand_pair_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 8;

  // Smallest n with 2**n >= value; evaluated at elaboration to size pointers.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/operand_pair_fifo_ram_2p.sv
// rtl/operand_pair_fifo_ram_2p.sv - register-array pair storage, synchronous write, asynchronous read
module fifo_ram_2p #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; the fifo never presents an unwritten slot as valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/operand_pair_fifo.sv
// rtl/operand_pair_fifo.sv - FWFT (A,B) pair fifo with drop detection
// Optional accepted/dropped pair counters under OPERAND_FIFO_STATS_EN.
module operand_pair_fifo
  import operand_pair_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = log2_ceil(DEPTH)
) (
  input  logic                  clkIn,
  input  logic                  rstnIn,
  input  logic [DATA_WIDTH-1:0] dataAIn,
  input  logic [DATA_WIDTH-1:0] dataBIn,
  input  logic                  validIn,
  output logic [DATA_WIDTH-1:0] dataAOut,
  output logic [DATA_WIDTH-1:0] dataBOut,
  output logic                  validOut,
  input  logic                  readyIn,
  output logic [ADDR_WIDTH:0]   countOut,
  output logic                  fullOut,
  output logic                  overflowOut,
  output logic [31:0]           pushCountOut,
  output logic [31:0]           dropCountOut
);

  localparam int                PAIR_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, pop, push, drop;
  logic [PAIR_WIDTH-1:0] rd_pair;

  assign full     = (count_q == FULL_COUNT);
  assign validOut = (count_q != '0);
  assign pop      = validOut & readyIn;
  // A pop in the same cycle frees the slot the incoming pair needs.
  assign push     = validIn & (!full | pop);
  assign drop     = validIn & full & !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_ram_2p #(
    .WIDTH      (PAIR_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i     (clkIn),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({dataAIn, dataBIn}),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_pair)
  );

  assign {dataAOut, dataBOut} = rd_pair;
  assign countOut             = count_q;
  assign fullOut              = full;
  assign overflowOut          = overflow_q;

`ifdef OPERAND_FIFO_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Counters hold at all-ones rather than wrap.
  always_comb begin
    push_cnt_d = push_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push && (push_cnt_q != '1)) push_cnt_d = push_cnt_q + 32'd1;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pushCountOut = push_cnt_q;
  assign dropCountOut = drop_cnt_q;
`else
  assign pushCountOut = '0;
  assign dropCountOut = '0;
`endif

endmodule

// File: tb/tb_operand_pair_fifo.sv
// tb/tb_operand_pair_fifo.sv - directed self-checking bench for operand_pair_fifo
module tb_operand_pair_fifo;

  localparam int DW = 32;
  localparam int AW = 3;
`ifdef OPERAND_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] data_a_in, data_b_in;
  logic          valid_in;
  logic [DW-1:0] data_a_out, data_b_out;
  logic          valid_out;
  logic          ready_in;
  logic [AW:0]   count_out;
  logic          full_out;
  logic          overflow_out;
  logic [31:0]   push_count_out, drop_count_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_pair_fifo dut (
    .clkIn        (clk),
    .rstnIn       (rstn),
    .dataAIn      (data_a_in),
    .dataBIn      (data_b_in),
    .validIn      (valid_in),
    .dataAOut     (data_a_out),
    .dataBOut     (data_b_out),
    .validOut     (valid_out),
    .readyIn      (ready_in),
    .countOut     (count_out),
    .fullOut      (full_out),
    .overflowOut  (overflow_out),
    .pushCountOut (push_count_out),
    .dropCountOut (drop_count_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    valid_in  = 1'b1;
    data_a_in = a;
    data_b_in = b;
    step();
    valid_in  = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int pushes, input int drops);
    check({tag, "_push_cnt"}, push_count_out, STATS ? 64'(pushes) : 64'd0);
    check({tag, "_drop_cnt"}, drop_count_out, STATS ? 64'(drops) : 64'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    data_a_in = '0;
    data_b_in = '0;
    step();
    step();
    check("rst_valid", valid_out, 0);
    check("rst_count", count_out, 0);
    check("rst_full", full_out, 0);
    check("rst_ovf", overflow_out, 0);
    check_stats("rst", 0, 0);
    rstn = 1'b1;
    step();

    // Three buffered pairs, then drain in order
    push_pair(32'h1, 32'h2);
    push_pair(32'h3, 32'h4);
    push_pair(32'h5, 32'h6);
    check("buf3_count", count_out, 3);
    check("buf3_valid", valid_out, 1);
    check("buf3_head_a", data_a_out, 32'h1);
    check("buf3_head_b", data_b_out, 32'h2);
    ready_in = 1'b1;
    step();
    check("drain1_a", data_a_out, 32'h3);
    check("drain1_b", data_b_out, 32'h4);
    step();
    check("drain2_a", data_a_out, 32'h5);
    check("drain2_b", data_b_out, 32'h6);
    step();
    check("drain3_valid", valid_out, 0);
    check("drain3_count", count_out, 0);
    step();
    check("empty_ready_count", count_out, 0);

    // Streaming pass-through with wrap of both pointers
    for (int i = 0; i < 20; i++) begin
      valid_in  = 1'b1;
      data_a_in = 32'h100 + i;
      data_b_in = 32'h200 + i;
      step();
      check($sformatf("stream%0d_a", i), data_a_out, 64'(32'h100 + i));
      check($sformatf("stream%0d_b", i), data_b_out, 64'(32'h200 + i));
      check($sformatf("stream%0d_count", i), count_out, 1);
    end
    valid_in = 1'b0;
    step();
    check("stream_end_count", count_out, 0);
    check("stream_end_ovf", overflow_out, 0);

    // Overflow: nine pushes into eight slots
    rstn = 1'b0;
    step();
    rstn     = 1'b1;
    ready_in = 1'b0;
    step();
    for (int i = 0; i < 8; i++) push_pair(32'h300 + i, 32'h400 + i);
    check("fill8_full", full_out, 1);
    check("fill8_count", count_out, 8);
    check("fill8_ovf", overflow_out, 0);
    push_pair(32'h3FF, 32'h4FF);
    check("drop_ovf", overflow_out, 1);
    check("drop_count", count_out, 8);
    check("drop_head_a", data_a_out, 32'h300);
    check_stats("drop", 8, 1);
    step();
    step();
    check("ovf_sticky", overflow_out, 1);
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain%0d_a", i), data_a_out, 64'(32'h300 + i));
      check($sformatf("ovf_drain%0d_b", i), data_b_out, 64'(32'h400 + i));
      step();
    end
    check("ovf_drained_valid", valid_out, 0);
    check("ovf_drained_ovf", overflow_out, 1);

    // Full fifo, push and pop in the same cycle
    rstn = 1'b0;
    step();
    rstn     = 1'b1;
    ready_in = 1'b0;
    step();
    for (int i = 0; i < 8; i++) push_pair(32'h500 + i, 32'h600 + i);
    ready_in = 1'b1;
    push_pair(32'hAAA, 32'hBBB);
    check("pp_count", count_out, 8);
    check("pp_full", full_out, 1);
    check("pp_ovf", overflow_out, 0);
    check_stats("pp", 9, 0);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("pp_drain%0d_a", i), data_a_out, 64'(32'h500 + i));
      step();
    end
    check("pp_new_a", data_a_out, 32'hAAA);
    check("pp_new_b", data_b_out, 32'hBBB);
    step();
    check("pp_empty_valid", valid_out, 0);

    // Asynchronous reset while holding five pairs and a set overflow flag
    ready_in = 1'b0;
    for (int i = 0; i < 9; i++) push_pair(32'h700 + i, 32'h800 + i);
    check("ar_pre_ovf", overflow_out, 1);
    ready_in = 1'b1;
    step();
    step();
    step();
    ready_in = 1'b0;
    check("ar_pre_count", count_out, 5);
    check("ar_pre_head", data_a_out, 32'h703);
    #2;
    rstn = 1'b0;
    #2;
    check("ar_valid", valid_out, 0);
    check("ar_count", count_out, 0);
    check("ar_ovf", overflow_out, 0);
    check("ar_full", full_out, 0);
    check_stats("ar", 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_pair(32'h777, 32'h888);
    check("post_ar_valid", valid_out, 1);
    check("post_ar_count", count_out, 1);
    check("post_ar_a", data_a_out, 32'h777);
    check("post_ar_b", data_b_out, 32'h888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
